// File: rtl/stickman_motion_if.sv
// ----------------------------------------------------------------------------
// stickman_motion_if
//   Bundles the signals exchanged between game_logic and the stickman physics
//   block. The master side (game_logic / testbench) drives the frame strobe,
//   key, game status and terrain height. The slave side (stickman_motion)
//   returns the stickman's position, velocity, airborne flag and animation
//   frame.
//
//   frame_clk       master->slave  ~60 Hz frame strobe, synchronous to Clk
//   keycode[7:0]    master->slave  last received key
//   status[3:0]     master->slave  {waiting,playing,win,lose}
//   GroundY[9:0]    master->slave  ground surface row under the stickman
//   StickmanBottom  slave->master  current bottom row of the stickman
//   StickmanVelY    slave->master  signed vertical velocity (+ = down)
//   Airborne        slave->master  1 while rising or falling
//   AnimFrame[1:0]  slave->master  run-cycle frame index 0..3
// ----------------------------------------------------------------------------
interface stickman_motion_if;
    logic              frame_clk;
    logic [7:0]        keycode;
    logic [3:0]        status;
    logic [9:0]        GroundY;
    logic [9:0]        StickmanBottom;
    logic signed [9:0] StickmanVelY;
    logic              Airborne;
    logic [1:0]        AnimFrame;

    modport master (
        output frame_clk, keycode, status, GroundY,
        input  StickmanBottom, StickmanVelY, Airborne, AnimFrame
    );

    modport slave (
        input  frame_clk, keycode, status, GroundY,
        output StickmanBottom, StickmanVelY, Airborne, AnimFrame
    );
endinterface

// File: rtl/stickman_motion.sv
// ----------------------------------------------------------------------------
// stickman_motion
//   Once per frame, integrates the stickman's jump/gravity physics against the
//   terrain height and advances the running-animation frame index.
//   Screen y grows downward; valid rows are 0..MAX_Y.
//
//   Clk     in   system clock
//   Reset   in   synchronous, active-high reset
//   bus     slave modport of stickman_motion_if (frame strobe, key, status,
//           ground height in; position, velocity, airborne, anim frame out)
// ----------------------------------------------------------------------------
module stickman_motion #(
    parameter int          START_Y    = 400,
    parameter int          MAX_Y      = 479,
    parameter int          JUMP_V     = 12,
    parameter int          GRAVITY    = 1,
    parameter int          MAX_FALL_V = 15,
    parameter int          STEP_UP    = 4,
    parameter int          ANIM_DIV   = 6,
    parameter logic [7:0]  JUMP_KEY   = 8'h2C
) (
    input  logic              Clk,
    input  logic              Reset,
    stickman_motion_if.slave  bus
);
    localparam logic [3:0] ST_WAIT = 4'b1000;
    localparam logic [3:0] ST_PLAY = 4'b0100;
    localparam int         CNT_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

    state_t            r_state,    w_state_nx;
    logic [9:0]        r_bottom,   w_bottom_nx;
    logic signed [9:0] r_vel,      w_vel_nx;
    logic [1:0]        r_anim,     w_anim_nx;
    logic [CNT_W-1:0]  r_anim_cnt, w_anim_cnt_nx;
    logic              r_jump_req, w_jump_req_nx;
    logic              r_frame_d;
    logic              r_key_prev;

    logic               w_tick;
    logic               w_key_is_jump;
    logic               w_press;
    logic               w_play;
    logic               w_wait;
    logic               w_jump;
    logic signed [10:0] w_bottom_s;
    logic signed [10:0] w_vel_s;
    logic signed [10:0] w_ground_s;
    logic signed [10:0] w_nb;
    logic signed [10:0] w_vel_sum;

    assign w_tick        = bus.frame_clk & ~r_frame_d;
    assign w_key_is_jump = (bus.keycode == JUMP_KEY);
    assign w_press       = w_key_is_jump & ~r_key_prev;
    assign w_play        = (bus.status == ST_PLAY);
    assign w_wait        = (bus.status == ST_WAIT);
    // A press landing on the tick cycle counts for that same tick.
    assign w_jump        = r_jump_req | (w_press & w_play);

    // 11-bit signed working copies so Bottom+vel can go below 0 or above MAX_Y.
    assign w_bottom_s = $signed({1'b0, r_bottom});
    assign w_vel_s    = {r_vel[9], r_vel};
    assign w_ground_s = $signed({1'b0, bus.GroundY});
    assign w_nb       = w_bottom_s + w_vel_s;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nx    = r_state;
        w_bottom_nx   = r_bottom;
        w_vel_nx      = r_vel;
        w_anim_nx     = r_anim;
        w_anim_cnt_nx = r_anim_cnt;
        w_vel_sum     = '0;
        // Requests never outlive a tick and are dropped outside PLAY.
        w_jump_req_nx = w_play & ~w_tick & w_jump;

        if (w_tick && w_wait) begin
            w_state_nx    = GROUNDED;
            w_bottom_nx   = 10'(START_Y);
            w_vel_nx      = '0;
            w_anim_nx     = '0;
            w_anim_cnt_nx = '0;
        end else if (w_tick && w_play) begin
            case (r_state)
                GROUNDED: begin
                    if (r_anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
                        w_anim_cnt_nx = '0;
                        w_anim_nx     = r_anim + 2'd1;
                    end else begin
                        w_anim_cnt_nx = r_anim_cnt + 1'b1;
                    end

                    if (w_jump) begin
                        w_vel_nx   = -$signed(10'(JUMP_V));
                        w_state_nx = RISING;
                    end else if (bus.GroundY > r_bottom) begin
                        w_vel_nx   = $signed(10'(GRAVITY));
                        w_state_nx = FALLING;
                    end else if ((r_bottom - bus.GroundY) <= 10'(STEP_UP)) begin
                        // Small rise (or none): climb onto it. Larger rises are
                        // left for game_logic to treat as a crash.
                        w_bottom_nx = bus.GroundY;
                    end
                end

                RISING, FALLING: begin
                    if (!r_vel[9] && (r_bottom <= bus.GroundY) && (w_nb >= w_ground_s)) begin
                        w_bottom_nx   = bus.GroundY;
                        w_vel_nx      = '0;
                        w_state_nx    = GROUNDED;
                        w_anim_cnt_nx = '0;
                    end else begin
                        if (w_nb < 0) begin
                            // Hit the top of the screen: kill the upward speed.
                            w_bottom_nx = '0;
                            w_vel_sum   = '0;
                        end else if (w_nb > $signed(11'(MAX_Y))) begin
                            w_bottom_nx = 10'(MAX_Y);
                            w_vel_sum   = w_vel_s;
                        end else begin
                            w_bottom_nx = w_nb[9:0];
                            w_vel_sum   = w_vel_s;
                        end
                        w_vel_sum = w_vel_sum + $signed(11'(GRAVITY));
                        if (w_vel_sum > $signed(11'(MAX_FALL_V))) begin
                            w_vel_sum = $signed(11'(MAX_FALL_V));
                        end
                        w_vel_nx   = w_vel_sum[9:0];
                        w_state_nx = (w_vel_sum < 0) ? RISING : FALLING;
                    end
                end

                default: w_state_nx = GROUNDED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= GROUNDED;
            r_bottom   <= 10'(START_Y);
            r_vel      <= '0;
            r_anim     <= '0;
            r_anim_cnt <= '0;
            r_jump_req <= 1'b0;
            r_frame_d  <= 1'b0;
            r_key_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bottom   <= w_bottom_nx;
            r_vel      <= w_vel_nx;
            r_anim     <= w_anim_nx;
            r_anim_cnt <= w_anim_cnt_nx;
            r_jump_req <= w_jump_req_nx;
            r_frame_d  <= bus.frame_clk;
            r_key_prev <= w_key_is_jump;
        end
    end

    assign bus.StickmanBottom = r_bottom;
    assign bus.StickmanVelY   = r_vel;
    assign bus.Airborne       = (r_state != GROUNDED);
    assign bus.AnimFrame      = r_anim;

endmodule

// File: tb/tb_stickman_motion.sv
// ----------------------------------------------------------------------------
// tb_stickman_motion
//   Self-checking bench for stickman_motion: constant-expectation vector table,
//   hand-written sequences for the jump/fall/freeze/reset scenarios, and a
//   randomized run compared cycle by cycle against a behavioural model.
// ----------------------------------------------------------------------------
module tb_stickman_motion;
    localparam logic [7:0] SPACE = 8'h2C;
    localparam logic [3:0] S_WAIT = 4'b1000;
    localparam logic [3:0] S_PLAY = 4'b0100;
    localparam logic [3:0] S_WIN  = 4'b0010;
    localparam logic [3:0] S_LOSE = 4'b0001;

    logic clk;
    logic rst;
    stickman_motion_if bus();

    stickman_motion dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: position/velocity as plain integers, one airborne flag.
    int m_y, m_v, m_anim, m_gcnt;
    bit m_air, m_req, m_prev, m_fd;

    typedef struct {
        logic [9:0] ground;
        int         exp_y;
        int         exp_v;
        bit         exp_air;
        int         exp_anim;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int y, input int v, input int air, input int anim);
        check({tag, ".bottom"}, int'(bus.StickmanBottom), y);
        check({tag, ".vel"},    int'(bus.StickmanVelY), v);
        check({tag, ".air"},    int'(bus.Airborne), air);
        check({tag, ".anim"},   int'(bus.AnimFrame), anim);
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, m_y, m_v, int'(m_air), m_anim);
    endtask

    // Advance the model by the Clk edge that is about to happen.
    task automatic model_step();
        bit key_is, press, tick, play, jump;
        int g, nb;
        key_is = (bus.keycode == SPACE);
        press  = key_is && !m_prev;
        tick   = bus.frame_clk && !m_fd;
        play   = (bus.status == S_PLAY);
        jump   = m_req || (press && play);
        g      = int'(bus.GroundY);
        if (rst) begin
            m_y = 400; m_v = 0; m_air = 0; m_anim = 0; m_gcnt = 0;
            m_req = 0; m_prev = 0; m_fd = 0;
            return;
        end
        if (tick && bus.status == S_WAIT) begin
            m_y = 400; m_v = 0; m_air = 0; m_anim = 0; m_gcnt = 0;
        end else if (tick && play) begin
            if (!m_air) begin
                m_gcnt++;
                if (m_gcnt == 6) begin
                    m_gcnt = 0;
                    m_anim = (m_anim + 1) % 4;
                end
                if (jump) begin
                    m_v = -12; m_air = 1;
                end else if (g > m_y) begin
                    m_v = 1; m_air = 1;
                end else if (m_y - g >= 1 && m_y - g <= 4) begin
                    m_y = g;
                end
            end else begin
                nb = m_y + m_v;
                if (m_v >= 0 && m_y <= g && nb >= g) begin
                    m_y = g; m_v = 0; m_air = 0; m_gcnt = 0;
                end else begin
                    if (nb < 0) begin
                        m_y = 0; m_v = 0;
                    end else if (nb > 479) begin
                        m_y = 479;
                    end else begin
                        m_y = nb;
                    end
                    m_v = (m_v + 1 > 15) ? 15 : m_v + 1;
                end
            end
        end
        m_req  = play && !tick && jump;
        m_prev = key_is;
        m_fd   = bus.frame_clk;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // One frame: strobe high two cycles, low two cycles.
    task automatic frame();
        bus.frame_clk = 1'b1;
        cycle(); cycle();
        bus.frame_clk = 1'b0;
        cycle(); cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    initial begin
        int min_y, jumps, snap_y, snap_v, snap_anim, g;
        bit prev_air;

        rst           = 1'b1;
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        bus.status    = S_PLAY;
        bus.GroundY   = 10'd400;

        // Reset state
        do_reset();
        check_outs("reset", 400, 0, 0, 0);

        // Vector table: step-up, large rise, drop + land, anim step
        tbl[0]  = '{10'd380, 400, 0, 0, 0};
        tbl[1]  = '{10'd397, 397, 0, 0, 0};
        tbl[2]  = '{10'd397, 397, 0, 0, 0};
        tbl[3]  = '{10'd400, 397, 1, 1, 0};
        tbl[4]  = '{10'd400, 398, 2, 1, 0};
        tbl[5]  = '{10'd400, 400, 0, 0, 0};
        tbl[6]  = '{10'd400, 400, 0, 0, 0};
        tbl[7]  = '{10'd400, 400, 0, 0, 0};
        tbl[8]  = '{10'd400, 400, 0, 0, 0};
        tbl[9]  = '{10'd400, 400, 0, 0, 0};
        tbl[10] = '{10'd400, 400, 0, 0, 0};
        tbl[11] = '{10'd400, 400, 0, 0, 1};
        for (int i = 0; i < 12; i++) begin
            bus.GroundY = tbl[i].ground;
            frame();
            check_outs($sformatf("vec%0d", i), tbl[i].exp_y, tbl[i].exp_v,
                       int'(tbl[i].exp_air), tbl[i].exp_anim);
        end

        // Animation cadence: 0,1,2,3,0 every 6 grounded ticks
        bus.status = S_WAIT; frame();
        check_outs("wait_anim", 400, 0, 0, 0);
        bus.status = S_PLAY;
        for (int k = 0; k < 24; k++) begin
            frame();
            check($sformatf("anim_tick%0d", k + 1), int'(bus.AnimFrame), ((k + 1) / 6) % 4);
        end

        // Single jump: peak 322, land at 400
        bus.keycode = SPACE; frame();
        bus.keycode = 8'h00;
        min_y = 1000;
        for (int k = 0; k < 30; k++) begin
            frame();
            if (int'(bus.StickmanBottom) < min_y) min_y = int'(bus.StickmanBottom);
            check_model("jump");
        end
        check("jump_peak", min_y, 322);
        check_outs("jump_land", 400, 0, 0, m_anim);

        // Held space over 40 ticks: exactly one jump
        jumps = 0; prev_air = 0;
        bus.keycode = SPACE;
        for (int k = 0; k < 40; k++) begin
            frame();
            if (bus.Airborne && !prev_air) jumps++;
            prev_air = bus.Airborne;
        end
        check("held_jumps", jumps, 1);
        check_outs("held_end", 400, 0, 0, m_anim);

        // WAIT -> PLAY via space: no jump
        bus.keycode = 8'h00; bus.status = S_WAIT; frame();
        bus.keycode = SPACE; cycle(); cycle();
        bus.status = S_PLAY;
        jumps = 0;
        for (int k = 0; k < 5; k++) begin
            frame();
            if (bus.Airborne) jumps++;
        end
        check("start_press_air", jumps, 0);
        bus.keycode = 8'h00;

        // Fall off a deep drop: vel 1..15 capped, Bottom clamps at 479
        bus.status = S_WAIT; frame();
        bus.status = S_PLAY; bus.GroundY = 10'd1000;
        for (int k = 1; k <= 20; k++) begin
            frame();
            check($sformatf("fall_vel%0d", k), int'(bus.StickmanVelY), (k > 15) ? 15 : k);
        end
        check_outs("fall_clamp", 479, 15, 1, m_anim);
        bus.GroundY = 10'd479; frame();
        check_outs("fall_land", 479, 0, 0, m_anim);
        bus.GroundY = 10'd479; frame();
        check_model("fall_ground");

        // Ground 479 from 400: lands exactly on 479
        bus.status = S_WAIT; frame();
        bus.status = S_PLAY;
        for (int k = 0; k < 16; k++) frame();
        check_outs("drop479", 479, 0, 0, m_anim);

        // Mid-air LOSE freezes; WAIT restores start
        bus.status = S_WAIT; frame();
        bus.status = S_PLAY; bus.GroundY = 10'd400;
        bus.keycode = SPACE; frame(); bus.keycode = 8'h00;
        for (int k = 0; k < 5; k++) frame();
        snap_y = m_y; snap_v = m_v; snap_anim = m_anim;
        check("lose_airborne", int'(bus.Airborne), 1);
        bus.status = S_LOSE;
        for (int k = 0; k < 5; k++) frame();
        check_outs("lose_frozen", snap_y, snap_v, 1, snap_anim);
        bus.status = S_WIN; frame();
        check_outs("win_frozen", snap_y, snap_v, 1, snap_anim);
        bus.status = S_WAIT; frame();
        check_outs("wait_restore", 400, 0, 0, 0);

        // Reset mid-jump
        bus.status = S_PLAY;
        bus.keycode = SPACE; frame(); bus.keycode = 8'h00;
        frame(); frame(); frame();
        rst = 1'b1; cycle(); rst = 1'b0;
        check_outs("reset_midjump", 400, 0, 0, 0);

        // Randomized run against the model
        for (int f = 0; f < 400; f++) begin
            int r, hi, lo;
            r = $urandom_range(0, 99);
            if (r < 70)      bus.status = S_PLAY;
            else if (r < 80) bus.status = S_WAIT;
            else if (r < 90) bus.status = S_LOSE;
            else if (r < 95) bus.status = S_WIN;
            else             bus.status = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 7) begin
                g = m_y + int'($urandom_range(0, 14)) - 6;
                if (g < 0) g = 0;
                if (g > 1023) g = 1023;
            end else begin
                g = int'($urandom_range(0, 1023));
            end
            bus.GroundY = 10'(g);
            rst = ($urandom_range(0, 99) == 0);
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 3);
            bus.frame_clk = 1'b1;
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) bus.frame_clk = 1'b0;
                r = $urandom_range(0, 9);
                if (r < 3)      bus.keycode = SPACE;
                else if (r < 5) bus.keycode = 8'h1A;
                else if (r < 7) bus.keycode = 8'h00;
                cycle();
                check_model("rand");
            end
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
